// File: rtl/i2s_tx_pkg.sv
// Shared audio constants for the I2S transmitter and its neighbours (clkdiv, synth core).
//   SAMPLE_WIDTH  : PCM sample width in bits
//   I2S_SLOT      : sclk bit slots per channel
//   I2S_SCLK_HALF : clk cycles per sclk half-period
//   LRCK_LEFT     : lrck level that selects the left channel
//   i2s_state_e   : transmitter framing state
package i2s_tx_pkg;

    localparam int unsigned SAMPLE_WIDTH  = 16;
    localparam int unsigned I2S_SLOT      = 32;
    localparam int unsigned I2S_SCLK_HALF = 4;
    localparam logic        LRCK_LEFT     = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_state_e;

endpackage

// File: rtl/i2s_tx_shifter.sv
// I2S bit engine: phase/slot counters, sclk generation and MSB-first shift register.
//   clk, rst       : system clock, synchronous active-high reset
//   load_i         : restart a channel slot sequence with load_data_i
//   load_data_i    : sample to serialise for the channel being started
//   run_i          : 1 = keep clocking bits, 0 = hold sclk/sdin low
//   sclk_o, sdin_o : registered I2S bit clock and data
//   last_slot_c_o  : slot counter is on the final slot of the channel
//   wrap_c_o       : final slot is ending this cycle (slot about to roll over)
module i2s_tx_shifter
    import i2s_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = SAMPLE_WIDTH,
    parameter int unsigned SLOT      = I2S_SLOT,
    parameter int unsigned SCLK_HALF = I2S_SCLK_HALF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             run_i,
    output logic             sclk_o,
    output logic             sdin_o,
    output logic             last_slot_c_o,
    output logic             wrap_c_o
);

    localparam int unsigned PH_W = $clog2(2 * SCLK_HALF);
    localparam int unsigned SL_W = $clog2(SLOT);

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [SL_W-1:0]  slot_q, slot_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             sclk_q, sclk_d;
    logic             sdin_q, sdin_d;
    logic             phase_end;

    assign phase_end     = (phase_q == PH_W'(2 * SCLK_HALF - 1));
    assign last_slot_c_o = (slot_q == SL_W'(SLOT - 1));
    assign wrap_c_o      = last_slot_c_o && phase_end;
    assign sclk_o        = sclk_q;
    assign sdin_o        = sdin_q;

    // Slot 0 carries the one-bit I2S delay; zeros shifted in pad the slots past the LSB.
    always_comb begin
        phase_d = phase_q;
        slot_d  = slot_q;
        shift_d = shift_q;
        sclk_d  = sclk_q;
        sdin_d  = sdin_q;
        if (load_i) begin
            phase_d = '0;
            slot_d  = '0;
            shift_d = load_data_i;
            sclk_d  = 1'b0;
            sdin_d  = 1'b0;
        end else if (!run_i) begin
            phase_d = '0;
            slot_d  = '0;
            sclk_d  = 1'b0;
            sdin_d  = 1'b0;
        end else if (phase_end) begin
            phase_d = '0;
            slot_d  = last_slot_c_o ? '0 : slot_q + SL_W'(1);
            sclk_d  = 1'b0;
            sdin_d  = shift_q[WIDTH-1];
            shift_d = shift_q << 1;
        end else begin
            phase_d = phase_q + PH_W'(1);
            if (phase_q == PH_W'(SCLK_HALF - 1)) begin
                sclk_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            slot_q  <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b0;
            sdin_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            slot_q  <= slot_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
            sdin_q  <= sdin_d;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: frames stereo PCM pairs onto sclk/sdin aligned to an external lrck.
//   clk, rst          : system clock, synchronous active-high reset
//   lrck              : word clock from clkdiv (0 = left, 1 = right)
//   s_left, s_right   : PCM pair, two's complement
//   s_valid, s_ready  : pair handshake into a one-entry buffer
//   sclk, sdin        : I2S bit clock and serial data
//   lrck_out          : lrck re-timed to line up with sclk/sdin
//   underrun          : pulse when a frame starts with no pair buffered
//   sync_err          : pulse when an lrck edge arrives early or goes missing
module i2s_tx
    import i2s_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = SAMPLE_WIDTH,
    parameter int unsigned SLOT      = I2S_SLOT,
    parameter int unsigned SCLK_HALF = I2S_SCLK_HALF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lrck,
    input  logic [WIDTH-1:0] s_left,
    input  logic [WIDTH-1:0] s_right,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             sclk,
    output logic             sdin,
    output logic             lrck_out,
    output logic             underrun,
    output logic             sync_err
);

    i2s_state_e       state_q, state_d;
    logic             lrck_q;
    logic [WIDTH-1:0] buf_left_q, buf_left_d, buf_right_q, buf_right_d;
    logic             buf_full_q, buf_full_d;
    logic [WIDTH-1:0] act_left_q, act_left_d, act_right_q, act_right_d;
    logic             s_ready_q, s_ready_d;
    logic             lrck_out_q, lrck_out_d;
    logic             underrun_q, underrun_d;
    logic             sync_err_q, sync_err_d;

    logic             lrck_edge, lrck_fall;
    logic             load, run;
    logic [WIDTH-1:0] load_data;
    logic             last_slot, wrap;

    assign lrck_edge = lrck ^ lrck_q;
    assign lrck_fall = lrck_edge && (lrck == LRCK_LEFT);

    assign s_ready  = s_ready_q;
    assign lrck_out = lrck_out_q;
    assign underrun = underrun_q;
    assign sync_err = sync_err_q;

    // Framing FSM, frame-start buffer transfer and handshake.
    always_comb begin
        state_d     = state_q;
        lrck_out_d  = lrck_out_q;
        buf_left_d  = buf_left_q;
        buf_right_d = buf_right_q;
        buf_full_d  = buf_full_q;
        act_left_d  = act_left_q;
        act_right_d = act_right_q;
        underrun_d  = 1'b0;
        sync_err_d  = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                lrck_out_d = lrck;
                if (lrck_fall) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (lrck_edge) begin
                    // Any edge realigns; only one landing outside the last slot is an error.
                    load       = 1'b1;
                    lrck_out_d = lrck;
                    sync_err_d = ~last_slot;
                end else if (wrap) begin
                    sync_err_d = 1'b1;
                    state_d    = IDLE;
                end
            end
        endcase

        if (load && lrck_fall) begin
            if (buf_full_q) begin
                act_left_d  = buf_left_q;
                act_right_d = buf_right_q;
                buf_full_d  = 1'b0;
            end else begin
                act_left_d  = '0;
                act_right_d = '0;
                underrun_d  = 1'b1;
            end
        end

        // s_ready_q is only high with the buffer empty, so this never collides with a transfer.
        if (s_valid && s_ready_q) begin
            buf_left_d  = s_left;
            buf_right_d = s_right;
            buf_full_d  = 1'b1;
        end

        s_ready_d = ~buf_full_d;
        run       = (state_d == RUN);
        // A left channel starts from the pair being transferred on this same edge.
        load_data = lrck_fall ? act_left_d : act_right_q;
    end

    always_ff @(posedge clk) begin
        lrck_q <= lrck;
        if (rst) begin
            state_q     <= IDLE;
            buf_left_q  <= '0;
            buf_right_q <= '0;
            buf_full_q  <= 1'b0;
            act_left_q  <= '0;
            act_right_q <= '0;
            s_ready_q   <= 1'b0;
            lrck_out_q  <= 1'b0;
            underrun_q  <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_left_q  <= buf_left_d;
            buf_right_q <= buf_right_d;
            buf_full_q  <= buf_full_d;
            act_left_q  <= act_left_d;
            act_right_q <= act_right_d;
            s_ready_q   <= s_ready_d;
            lrck_out_q  <= lrck_out_d;
            underrun_q  <= underrun_d;
            sync_err_q  <= sync_err_d;
        end
    end

    i2s_tx_shifter #(
        .WIDTH    (WIDTH),
        .SLOT     (SLOT),
        .SCLK_HALF(SCLK_HALF)
    ) u_shifter (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load),
        .load_data_i  (load_data),
        .run_i        (run),
        .sclk_o       (sclk),
        .sdin_o       (sdin),
        .last_slot_c_o(last_slot),
        .wrap_c_o     (wrap)
    );

endmodule
